bidir_pad_ctrl: RTL and testbench

- Sequences an N-bit bank of tri-state bidirectional pads (pad drive data I, enable T, input O) on behalf of two requesters.
- Requesters are typically a PicoBlaze port-interface and a DMA-style engine.
- Arbitrates round-robin and enforces drive-hold, bus-turnaround and read-settle timing, so the pad bank never drives while released and never samples while driven.
- Sits between the requesters and the IOBUF instances at the top level.

---
 rtl/bidir_pad_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bidir_pad_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_pad_ctrl.sv
// Round-robin sequencer for a tri-state pad bank shared by two requesters.
// Optional write-verify comparator enabled by defining BIDIR_PAD_WRITE_VERIFY_EN.
module bidir_pad_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DRIVE_CYC  = 2,
  parameter int TURN_CYC   = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [1:0]       rnw,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] pad_i,
  output logic             pad_t,
  input  logic [WIDTH-1:0] pad_o
);

  // state  | meaning
  // IDLE   | pads released, waiting for a request to grant
  // DRIVE  | pads driven with latched write data
  // TURN   | pads released after a write, bus turnaround
  // SAMPLE | pads released, settling before rdata capture
  // DONE   | done[grant] high until req[grant] drops

  // Illegal timing parameters stop elaboration rather than build a broken counter.
  if (DRIVE_CYC < 1 || DRIVE_CYC > 255) begin : g_bad_drive
    $error("bidir_pad_ctrl: DRIVE_CYC must be 1..255");
  end
  if (TURN_CYC < 1 || TURN_CYC > 255) begin : g_bad_turn
    $error("bidir_pad_ctrl: TURN_CYC must be 1..255");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("bidir_pad_ctrl: SETTLE_CYC must be 1..255");
  end

  localparam logic [7:0] DRIVE_LD  = 8'(DRIVE_CYC - 1);
  localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_TURN   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             sel;
  logic             pad_t_d, busy_d;
  logic [WIDTH-1:0] pad_i_d, rdata_d;
  logic [1:0]       done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      pad_t   <= 1'b1;
      pad_i   <= '0;
      rdata   <= '0;
      done    <= 2'b00;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      pad_t   <= pad_t_d;
      pad_i   <= pad_i_d;
      rdata   <= rdata_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    sel     = 1'b0;
    pad_t_d = 1'b1;
    pad_i_d = pad_i;
    rdata_d = rdata;
    done_d  = done;
    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // last_q names the requester served most recently; the other one wins a tie
          sel   = (req == 2'b11) ? ~last_q : req[1];
          gnt_d = sel;
          if (rnw[sel]) begin
            state_d = S_SAMPLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = S_DRIVE;
            cnt_d   = DRIVE_LD;
            pad_t_d = 1'b0;
            pad_i_d = sel ? wdata1 : wdata0;
          end
        end
      end
      S_DRIVE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_TURN;
          cnt_d   = TURN_LD;
        end else begin
          pad_t_d = 1'b0;
          cnt_d   = cnt_q - 8'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
          done_d  = 2'b01 << gnt_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
          rdata_d = pad_o;
          done_d  = 2'b01 << gnt_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        if (!req[gnt_q]) begin
          state_d = S_IDLE;
          done_d  = 2'b00;
          last_d  = gnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 2'b00;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

`ifdef BIDIR_PAD_WRITE_VERIFY_EN
  logic err_q;

  // Pads have been driven for the whole window by the last DRIVE edge; any difference is contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (state_q == S_DRIVE && cnt_q == 8'd0 && pad_o != pad_i) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// Bench for bidir_pad_ctrl: transaction-level timing model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bidir_pad_ctrl;
  localparam int WIDTH      = 8;
  localparam int DRIVE_CYC  = 2;
  localparam int TURN_CYC   = 1;
  localparam int SETTLE_CYC = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       req, rnw;
  logic [WIDTH-1:0] wdata0, wdata1, pad_o_drv, pad_o;
  logic             pad_loop;
  logic [1:0]       done;
  logic [WIDTH-1:0] rdata, pad_i;
  logic             busy, err, pad_t;

  assign pad_o = pad_loop ? pad_i : pad_o_drv;

  bidir_pad_ctrl #(
    .WIDTH(WIDTH), .DRIVE_CYC(DRIVE_CYC), .TURN_CYC(TURN_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rnw(rnw), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .rdata(rdata), .busy(busy), .err(err), .pad_i(pad_i), .pad_t(pad_t),
    .pad_o(pad_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one operation at a time, described by grant cycle and latency.
  bit               m_busy, m_gnt, m_rd, m_last, m_err;
  int               cyc, g;
  logic [WIDTH-1:0] m_padi, m_rdata;

  function automatic int lat(input bit rd);
    return rd ? 1 + SETTLE_CYC : 1 + DRIVE_CYC + TURN_CYC;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int k;
    if (!reset_n) begin
      m_busy = 0; m_last = 1; m_err = 0; m_gnt = 0; m_rd = 0;
      m_padi = '0; m_rdata = '0; cyc = 0; g = 0;
    end else begin
      if (!m_busy) begin
        if (req != 2'b00) begin
          m_gnt  = (req == 2'b11) ? !m_last : req[1];
          m_rd   = rnw[m_gnt];
          g      = cyc;
          m_busy = 1;
          if (!m_rd) m_padi = m_gnt ? wdata1 : wdata0;
        end
      end else begin
        k = cyc - g;
        if (m_rd && k == SETTLE_CYC) m_rdata = pad_o;
`ifdef BIDIR_PAD_WRITE_VERIFY_EN
        if (!m_rd && k == DRIVE_CYC && pad_o != m_padi) m_err = 1;
`endif
        if (k >= lat(m_rd) && !req[m_gnt]) begin
          m_busy = 0;
          m_last = m_gnt;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin : compare
    int   k;
    logic exp_t;
    logic [1:0] exp_done;
    if (reset_n) begin
      k        = cyc - g;
      exp_t    = 1'b1;
      exp_done = 2'b00;
      if (m_busy) begin
        if (!m_rd && k >= 1 && k <= DRIVE_CYC) exp_t = 1'b0;
        if (k >= lat(m_rd)) exp_done = 2'b01 << m_gnt;
      end
      check("pad_t", pad_t, exp_t);
      check("pad_i", pad_i, m_padi);
      check("done", done, exp_done);
      check("busy", busy, m_busy);
      check("rdata", rdata, m_rdata);
      check("err", err, m_err);
    end
  end

  // Call right after a negedge with req already raised; reports latency in cycles.
  task automatic run_op(output int fd, output int dc, output logic [WIDTH-1:0] dv,
                        output logic [WIDTH-1:0] rd_at_done);
    fd = -1; dc = 0; dv = '0; rd_at_done = '0;
    for (int n = 1; n <= 40 && fd < 0; n++) begin
      @(negedge clk);
      if (pad_t == 1'b0) begin
        dc++;
        dv = pad_i;
      end
      if (done != 2'b00) begin
        fd         = n;
        rd_at_done = rdata;
      end
    end
  endtask

  initial begin
    int               fd, dc, ops, nwin, rel, min_gap;
    logic [WIDTH-1:0] dv, rdv;
    logic             prev_t;
    int               order[6];
    logic [WIDTH-1:0] win_val[2];

    req = 2'b00; rnw = 2'b00; wdata0 = '0; wdata1 = '0; pad_o_drv = '0; pad_loop = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pad_t", pad_t, 1'b1);
    check("rst_pad_i", pad_i, 8'h00);
    check("rst_done", done, 2'b00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    reset_n = 1'b1;

    // Contention then fairness: both requesters write continuously.
    wdata0 = 8'h11; wdata1 = 8'h22; rnw = 2'b00; req = 2'b11;
    ops = 0; nwin = 0; rel = 0; min_gap = 1000; prev_t = 1'b1;
    foreach (order[i]) order[i] = -1;
    win_val[0] = '0; win_val[1] = '0;
    for (int n = 0; n < 300 && ops < 6; n++) begin
      @(negedge clk);
      if (pad_t == 1'b0) begin
        if (prev_t) begin
          if (nwin > 0 && rel < min_gap) min_gap = rel;
          if (nwin < 2) win_val[nwin] = pad_i;
          nwin++;
        end
        rel = 0;
      end else begin
        rel++;
      end
      prev_t = pad_t;
      if (req != 2'b11) req = 2'b11;
      else if (done != 2'b00) begin
        order[ops] = done[1] ? 1 : 0;
        ops++;
        req = (ops == 6) ? 2'b00 : (req & ~done);
      end
    end
    check("cont_first_val", win_val[0], 8'h11);
    check("cont_second_val", win_val[1], 8'h22);
    check("cont_gap_ok", (min_gap >= TURN_CYC), 1'b1);
    for (int i = 0; i < 6; i++) check($sformatf("fair_order%0d", i), order[i], i % 2);
    for (int n = 0; n < 50 && busy; n++) @(negedge clk);
    check("fair_drain", busy, 1'b0);

    // Single write with defaults.
    @(negedge clk);
    wdata0 = 8'hA5; rnw = 2'b00; req = 2'b01;
    run_op(fd, dc, dv, rdv);
    check("wr_latency", fd, 4);
    check("wr_drive_cycles", dc, 2);
    check("wr_drive_val", dv, 8'hA5);
    wdata0 = 8'h00;
    repeat (3) @(negedge clk);
    check("wr_done_held", done, 2'b01);
    req = 2'b00;
    @(negedge clk);
    check("wr_busy_after", busy, 1'b0);
    check("wr_done_after", done, 2'b00);

    // Single read.
    @(negedge clk);
    pad_loop = 1'b0; pad_o_drv = 8'h3C; rnw = 2'b10; req = 2'b10;
    run_op(fd, dc, dv, rdv);
    check("rd_latency", fd, 3);
    check("rd_drive_cycles", dc, 0);
    check("rd_data", rdv, 8'h3C);
    check("rd_done", done, 2'b10);
    req = 2'b00;
    @(negedge clk);

    // Asynchronous reset in the second DRIVE cycle.
    pad_loop = 1'b1; wdata0 = 8'h5A; rnw = 2'b00; req = 2'b01;
    repeat (2) @(negedge clk);
    check("mid_pre_pad_t", pad_t, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("mid_async_pad_t", pad_t, 1'b1);
    check("mid_async_done", done, 2'b00);
    check("mid_async_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(fd, dc, dv, rdv);
    check("mid_re_latency", fd, 4);
    check("mid_re_drive_cycles", dc, 2);
    check("mid_re_drive_val", dv, 8'h5A);
    req = 2'b00;
    @(negedge clk);

    // Write verify against a stuck pad bit.
    pad_loop = 1'b0; pad_o_drv = 8'hFE; wdata0 = 8'hFF; req = 2'b01;
    run_op(fd, dc, dv, rdv);
    req = 2'b00;
    @(negedge clk);
`ifdef BIDIR_PAD_WRITE_VERIFY_EN
    check("verify_err_set", err, 1'b1);
    pad_loop = 1'b1; wdata0 = 8'h33; req = 2'b01;
    run_op(fd, dc, dv, rdv);
    req = 2'b00;
    @(negedge clk);
    check("verify_err_sticky", err, 1'b1);
    #1 reset_n = 1'b0;
    #1 check("verify_err_reset", err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
`else
    check("verify_err_off", err, 1'b0);
`endif

    // Randomized traffic, including early req drops, late rnw changes and a reset pulse.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            rnw[i] = 1'($urandom_range(1));
          end
        end else if (done[i] && $urandom_range(1) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(40) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(15) == 0) rnw = 2'($urandom_range(3));
      wdata0    = 8'($urandom);
      wdata1    = 8'($urandom);
      pad_o_drv = 8'($urandom);
      pad_loop  = ($urandom_range(3) != 0);
      if (n == 2000) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
